// File: rtl/wide_add_pkg.sv
// Shared types and constants for the multi-precision adder sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wide_add_pkg;

  // Word width is pinned to the shared 16-bit adder datapath.
  localparam int WORD_BITS = 16;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_16bit.sv
// Combinational 16-bit adder with carry in and carry (overflow) out.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the output follows the inputs.
module adder_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_carry_in,
  output logic [15:0] o_sum,
  output logic        o_overflow
);

  // The 17-bit result keeps the carry out of bit 15.
  assign {o_overflow, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {16'd0, i_carry_in};

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide adder: NUM_WORDS x 16-bit sum on one shared adder_16bit, LS word first.
// Latency: done pulses NUM_WORDS cycles after the accepting edge; busy spans NUM_WORDS+1 cycles.
// Backpressure: start is only sampled in IDLE; requests made while busy are dropped.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int NUM_WORDS = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic [NUM_WORDS*WORD_BITS-1:0] i_a,
  input  logic [NUM_WORDS*WORD_BITS-1:0] i_b,
  input  logic                           i_carry_in,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [NUM_WORDS*WORD_BITS-1:0] o_sum,
  output logic                           o_overflow
);

  localparam int                IDX_W    = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t                         r_state;
  logic [NUM_WORDS*WORD_BITS-1:0] r_a;
  logic [NUM_WORDS*WORD_BITS-1:0] r_b;
  logic [NUM_WORDS*WORD_BITS-1:0] r_sum;
  logic                           r_carry;
  logic                           r_overflow;
  logic [IDX_W-1:0]               r_idx;
  logic                           r_busy;
  logic                           r_done;

  logic [WORD_BITS-1:0]           w_a_word;
  logic [WORD_BITS-1:0]           w_b_word;
  logic [WORD_BITS-1:0]           w_add_sum;
  logic                           w_add_ovf;
  logic [NUM_WORDS-1:0]           w_word_en;

  // Select the current operand words and decode the per-word result write enable from idx.
  always_comb begin
    w_a_word  = '0;
    w_b_word  = '0;
    w_word_en = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_word     = r_a[i*WORD_BITS +: WORD_BITS];
        w_b_word     = r_b[i*WORD_BITS +: WORD_BITS];
        w_word_en[i] = (r_state == EXEC);
      end
    end
  end

  adder_16bit u_adder (
    .i_a        (w_a_word),
    .i_b        (w_b_word),
    .i_carry_in (r_carry),
    .o_sum      (w_add_sum),
    .o_overflow (w_add_ovf)
  );

  // Control FSM with registered busy/done; operands are captured only on acceptance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= EXEC;
            r_a     <= i_a;
            r_b     <= i_b;
            r_carry <= i_carry_in;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        EXEC: begin
          for (int i = 0; i < NUM_WORDS; i++) begin
            if (w_word_en[i]) begin
              r_sum[i*WORD_BITS +: WORD_BITS] <= w_add_sum;
            end
          end
          // Carry ripples into the next word on the following cycle.
          r_carry <= w_add_ovf;
          if (r_idx == LAST_IDX) begin
            r_overflow <= w_add_ovf;
            r_state    <= DONE;
            r_done     <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_sum      = r_sum;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer at the default NUM_WORDS=4.
// Latency: checks done at NUM_WORDS cycles after acceptance and busy length NUM_WORDS+1.
// Backpressure: exercises start while busy, held start, and reset abort.
module tb_wide_add_sequencer;

  localparam int NW = 4;
  localparam int W  = NW * 16;

  typedef struct packed {
    logic         ovf;
    logic [W-1:0] sum;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         ovf;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   busy_len = 0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;
  logic aborted = 1'b0;

  wide_add_sequencer #(.NUM_WORDS(NW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_a        (a),
    .i_b        (b),
    .i_carry_in (cin),
    .o_busy     (busy),
    .o_done     (done),
    .o_sum      (sum),
    .o_overflow (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard on every done and checks handshake timing.
  always @(negedge clk) begin
    if (busy) busy_len = busy_len + 1;
    if (done) begin
      chk("done_latency", W'(busy_len), W'(NW + 1));
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum", sum, e.sum);
        chk("overflow", W'(ovf), W'(e.ovf));
      end
    end
    if (prev_done) chk("busy_after_done", W'(busy), W'(0));
    if (!busy && prev_busy) begin
      if (!aborted) chk("busy_length", W'(busy_len), W'(NW + 1));
      busy_len = 0;
    end
    prev_busy = busy;
    prev_done = done;
  end

  task automatic push_exp(input logic [W-1:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    exp_q.push_back(e);
  endtask

  // Issue one request from a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
    a     = av;
    b     = bv;
    cin   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", W'(busy), W'(0));
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", W'(done), W'(1));
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_done"}, W'(done), W'(0));
    chk({tag, "_sum"}, sum, W'(0));
    chk({tag, "_ovf"}, W'(ovf), W'(0));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    a     = {W{1'b1}};
    b     = {W{1'b1}};
    cin   = 1'b1;

    // Reset held two cycles with start high: nothing may be accepted.
    @(negedge clk);
    chk_cleared("rst1");
    @(negedge clk);
    chk_cleared("rst2");
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk_cleared("post_rst");

    // Carry across the word 0/1 boundary.
    push_exp(64'h0000_0000_0001_0000, 1'b0);
    issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    wait_idle();

    // Carry_in ripples through every word.
    push_exp(64'h0, 1'b1);
    issue({W{1'b1}}, 64'h0, 1'b1);
    wait_idle();

    // Max operands with start held; inputs change mid-operation and the
    // second request is taken right after DONE returns to IDLE.
    push_exp({W{1'b1}}, 1'b1);
    push_exp(64'h0, 1'b0);
    a     = {W{1'b1}};
    b     = {W{1'b1}};
    cin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    a     = 64'h0;
    b     = 64'h0;
    cin   = 1'b0;
    wait_done();
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("held_start_reaccept", W'(busy), W'(1));
    wait_idle();

    // Start pulsed while busy at idx=1 is ignored.
    push_exp(64'h3, 1'b0);
    issue(64'h1, 64'h2, 1'b0);
    @(negedge clk);
    a     = {W{1'b1}};
    b     = {W{1'b1}};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Reset at idx=2 aborts with no done and clears the partial sum.
    aborted = 1'b1;
    issue(64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_cleared("abort");
    @(negedge clk);
    aborted = 1'b0;

    push_exp(64'd13, 1'b0);
    issue(64'd5, 64'd7, 1'b1);
    wait_idle();
    repeat (2) @(negedge clk);

    chk("pending_results", W'(exp_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-precision adder controller. It computes a NUM_WORDS x 16-bit sum by sequencing a single shared adder_16bit instance one word per clock, least-significant word first. The carry out of each word is chained into the carry_in of the next. It sits between a requesting datapath (start/busy/done handshake) and the combinational 16-bit adder, so wide additions can run without replicating adder hardware.

## Interface
- NUM_WORDS, 4, number of 16-bit words per operand; legal range 2..16.
- WORD_BITS, 16, word width; fixed to match adder_16bit and not overridable.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a new addition; sampled only in IDLE.
- a  in  NUM_WORDS*16  operand A; word i is bits [16i+15:16i].
- b  in  NUM_WORDS*16  operand B; same word mapping as a.
- carry_in  in  1  carry into word 0.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the result is complete.
- sum  out  NUM_WORDS*16  result register.
- overflow  out  1  carry out of the most-significant word (unsigned overflow).

## Operation
- FSM has three states: IDLE, EXEC, DONE.
- IDLE → EXEC when start=1:
  - Latch a, b into operand registers.
  - Latch carry_in into the carry register.
  - idx <= 0.
- IDLE with start=0: hold state and all outputs.
- EXEC, each cycle:
  - Drive adder with a_reg word idx, b_reg word idx and the carry register.
  - sum word idx <= adder sum; carry register <= adder overflow.
  - If idx == NUM_WORDS-1: overflow <= adder overflow, go to DONE. Otherwise idx <= idx+1.
- DONE: done=1, then unconditionally → IDLE.
- Inputs are sampled only on acceptance:
  - start during EXEC or DONE is ignored.
  - a, b, carry_in changes after acceptance have no effect on the running operation.
- A start held high continuously yields one operation every NUM_WORDS+2 cycles (DONE returns to IDLE, which then accepts).
- Partial results: sum words update progressively during EXEC. sum and overflow are valid from the DONE cycle until the next accepted start.
- Arithmetic: {overflow, sum} == a + b + carry_in, with width NUM_WORDS*16+1 and no truncation.
- Reset:
  - rst=1 on a clock edge forces IDLE and clears sum, overflow, operand registers, carry register and idx.
  - busy and done are 0 in the following cycle.
  - rst has priority over start. Reset mid-EXEC aborts with no done pulse.

## Timing
- Reset values: busy=0, done=0, sum=0, overflow=0.
- Start accepted at edge E0 → busy=1 from E0 through E(NUM_WORDS+1).
- done=1 for exactly the cycle between E(NUM_WORDS) and E(NUM_WORDS+1). Latency from accepting edge to done is NUM_WORDS cycles (4 at default).
- done and busy are Moore outputs (decoded from state registers). No combinational path from inputs to outputs.
- adder_16bit is purely combinational. Its a→sum/overflow path plus register setup must close within one clk period.

## Structure
- Package wide_add_pkg holds:
  - state enum typedef (IDLE, EXEC, DONE), 2-bit encoding;
  - constant WORD_BITS = 16.
- One adder_16bit instance (existing module) is the only sub-module.
- Word select is a mux on idx; sum write is a per-word enable decoded from idx.
- idx counter width is $clog2(NUM_WORDS).

## Test plan
- Reset: rst=1 for 2 cycles, start=1 held → busy=0, done=0, sum=0, overflow=0 throughout; no start is accepted.
- Word-boundary carry: a=0x0000_0000_0000_FFFF, b=0x1, carry_in=0 → sum=0x0000_0000_0001_0000, overflow=0. busy is high for 5 cycles; done pulses once, exactly 4 cycles after the accepting edge.
- Full ripple: a=all ones, b=0, carry_in=1 → sum=0, overflow=1.
- Max operands: a=b=all ones, carry_in=1 → sum=all ones, overflow=1. Then a=b=0, carry_in=0 → sum=0, overflow=0 (prior result fully overwritten).
- Busy protection: start op a=0x1, b=0x2. At EXEC idx=1, pulse start with a=b=all ones → ignored. Result sum=0x3, overflow=0, single done pulse.
- Abort: start op, assert rst for one cycle at idx=2 → next cycle IDLE, sum=0, no done pulse. A following start with a=5, b=7, carry_in=1 → sum=13, overflow=0.
